// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM sequencing lw/sw/R-type/beq/addi/j
// through the shared datapath, with reset-gated write strobes.
module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic [2:0] ALUControl,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       PCEn,
    output logic [3:0] State
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    state_t     state;
    state_t     nextState;
    logic       pcWrite;
    logic       branch;
    logic       irWriteRaw;
    logic       memWriteRaw;
    logic       regWriteRaw;
    logic [2:0] functAlu;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= nextState;
    end

    // Unused encodings 12-15 fall through the default and recover to FETCH.
    always_comb begin
        nextState = FETCH;
        case (state)
            FETCH:    nextState = DECODE;
            DECODE: begin
                case (Op)
                    OP_LW, OP_SW: nextState = MEMADR;
                    OP_RTYPE:     nextState = EXECUTE;
                    OP_BEQ:       nextState = BRANCH;
                    OP_ADDI:      nextState = ADDIEXEC;
                    OP_J:         nextState = JUMP;
                    default:      nextState = FETCH;
                endcase
            end
            MEMADR:   nextState = (Op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:    nextState = MEMWB;
            EXECUTE:  nextState = ALUWB;
            ADDIEXEC: nextState = ADDIWB;
            default:  nextState = FETCH;
        endcase
    end

    always_comb begin
        functAlu = ALU_ADD;
        case (Funct)
            6'b100000: functAlu = ALU_ADD;
            6'b100010: functAlu = ALU_SUB;
            6'b100100: functAlu = ALU_AND;
            6'b100101: functAlu = ALU_OR;
            6'b101010: functAlu = ALU_SLT;
            default:   functAlu = ALU_ADD;
        endcase
    end

    always_comb begin
        ALUControl  = ALU_ADD;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSrc       = 2'b00;
        IorD        = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        irWriteRaw  = 1'b0;
        memWriteRaw = 1'b0;
        regWriteRaw = 1'b0;
        pcWrite     = 1'b0;
        branch      = 1'b0;
        case (state)
            FETCH: begin
                ALUSrcB    = 2'b01;
                irWriteRaw = 1'b1;
                pcWrite    = 1'b1;
            end
            DECODE:   ALUSrcB = 2'b11;
            MEMADR, ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD:    IorD = 1'b1;
            MEMWR: begin
                IorD        = 1'b1;
                memWriteRaw = 1'b1;
            end
            MEMWB: begin
                MemtoReg    = 1'b1;
                regWriteRaw = 1'b1;
            end
            EXECUTE: begin
                ALUSrcA    = 1'b1;
                ALUControl = functAlu;
            end
            ALUWB: begin
                RegDst      = 1'b1;
                regWriteRaw = 1'b1;
            end
            ADDIWB:   regWriteRaw = 1'b1;
            BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = 2'b01;
                branch     = 1'b1;
            end
            JUMP: begin
                PCSrc   = 2'b10;
                pcWrite = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are masked by reset directly so nothing writes while held in FETCH.
    assign IRWrite  = irWriteRaw  & ~reset;
    assign MemWrite = memWriteRaw & ~reset;
    assign RegWrite = regWriteRaw & ~reset;
    assign PCEn     = (pcWrite | (branch & Zero)) & ~reset;
    assign State    = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: a driver pushes per-cycle expectations
// from an instruction-level model; a negedge monitor pops and compares.
module tb_mips_multicycle_ctrl;

    logic       clk;
    logic       reset;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic [2:0] ALUControl;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, PCEn;
    logic [3:0] State;

    typedef struct packed {
        logic [3:0]  st;
        logic [14:0] outs;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    mips_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
        .ALUControl(ALUControl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .PCEn(PCEn), .State(State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [14:0] dutOuts;
    assign dutOuts = {ALUControl, ALUSrcA, ALUSrcB, PCSrc, IorD, MemWrite, IRWrite,
                      RegDst, MemtoReg, RegWrite, PCEn};

    // Step sequence each instruction class walks through, as state numbers.
    function automatic int pathLen(logic [5:0] op);
        case (op)
            6'b100011: return 5;
            6'b101011, 6'b000000, 6'b001000: return 4;
            6'b000100, 6'b000010: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int pathState(logic [5:0] op, int idx);
        int lw[5]   = '{0, 1, 2, 3, 4};
        int sw[4]   = '{0, 1, 2, 5};
        int rt[4]   = '{0, 1, 6, 7};
        int ad[4]   = '{0, 1, 9, 10};
        int bq[3]   = '{0, 1, 8};
        int jp[3]   = '{0, 1, 11};
        case (op)
            6'b100011: return lw[idx];
            6'b101011: return sw[idx];
            6'b000000: return rt[idx];
            6'b001000: return ad[idx];
            6'b000100: return bq[idx];
            6'b000010: return jp[idx];
            default:   return idx;
        endcase
    endfunction

    function automatic logic [2:0] aluFor(logic [5:0] f);
        if (f == 6'b100010) return 3'b110;
        if (f == 6'b100100) return 3'b000;
        if (f == 6'b100101) return 3'b001;
        if (f == 6'b101010) return 3'b111;
        return 3'b010;
    endfunction

    function automatic logic [14:0] expOut(int st, logic [5:0] f, logic z, logic inReset);
        logic [2:0] alu = 3'b010;
        logic       srcA = 0;
        logic [1:0] srcB = 0, pcs = 0;
        logic       iord = 0, mw = 0, irw = 0, rd = 0, mtr = 0, rw = 0, pcen = 0;
        case (st)
            0:  begin srcB = 2'b01; irw = 1; pcen = 1; end
            1:  srcB = 2'b11;
            2, 9: begin srcA = 1; srcB = 2'b10; end
            3:  iord = 1;
            4:  begin mtr = 1; rw = 1; end
            5:  begin iord = 1; mw = 1; end
            6:  begin srcA = 1; alu = aluFor(f); end
            7:  begin rd = 1; rw = 1; end
            8:  begin srcA = 1; alu = 3'b110; pcs = 2'b01; pcen = z; end
            10: rw = 1;
            11: begin pcs = 2'b10; pcen = 1; end
            default: ;
        endcase
        if (inReset) begin mw = 0; irw = 0; rw = 0; pcen = 0; end
        return {alu, srcA, srcB, pcs, iord, mw, irw, rd, mtr, rw, pcen};
    endfunction

    task automatic checkOutput(string name, logic [14:0] act, logic [14:0] req);
        checks++;
        if (act === req) passed++;
        else $display("[TB] FAIL %s: got %h required %h at %0t", name, act, req, $time);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("state", {11'd0, State}, {11'd0, e.st});
            checkOutput("outputs", dutOuts, e.outs);
        end
    end

    task automatic pushReset();
        exp_t e;
        e.st   = 4'd0;
        e.outs = expOut(0, Funct, Zero, 1'b1);
        sb.push_back(e);
    endtask

    // zeroMode: 0/1 force Zero, 2 randomises it every cycle; abortAt < 0 runs to completion.
    task automatic applyStimulus(logic [5:0] op, logic [5:0] funct, int zeroMode, int abortAt);
        int len = pathLen(op);
        for (int i = 0; i < len; i++) begin
            exp_t e;
            @(posedge clk);
            #1;
            if (i == abortAt) begin
                reset = 1'b1;
                pushReset();
                return;
            end
            reset = 1'b0;
            Op    = op;
            Funct = funct;
            Zero  = (zeroMode == 2) ? 1'($urandom_range(0, 1)) : zeroMode[0];
            e.st   = 4'(pathState(op, i));
            e.outs = expOut(pathState(op, i), funct, Zero, 1'b0);
            sb.push_back(e);
        end
    endtask

    function automatic logic isLegal(logic [5:0] op);
        return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    endfunction

    initial begin
        logic [5:0] legalOps[6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
        logic [5:0] functs[5]   = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        reset = 1'b1;
        Op    = 6'd0;
        Funct = 6'd0;
        Zero  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            pushReset();
        end

        applyStimulus(6'b100011, 6'b000000, 2, -1);
        applyStimulus(6'b000000, 6'b101010, 2, -1);
        applyStimulus(6'b000100, 6'b000000, 1, -1);
        applyStimulus(6'b000100, 6'b000000, 0, -1);
        applyStimulus(6'b111111, 6'b000000, 1, -1);
        applyStimulus(6'b101011, 6'b000000, 2, 2);
        applyStimulus(6'b000010, 6'b000000, 2, -1);

        for (int n = 0; n < 150; n++) begin
            logic [5:0] op;
            logic [5:0] f;
            int         abortAt;
            if ($urandom_range(0, 6) == 6) begin
                op = 6'($urandom_range(0, 63));
                while (isLegal(op)) op = 6'($urandom_range(0, 63));
            end else begin
                op = legalOps[$urandom_range(0, 5)];
            end
            f = ($urandom_range(0, 1) == 1) ? functs[$urandom_range(0, 4)] : 6'($urandom_range(0, 63));
            abortAt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, pathLen(op) - 1)) : -1;
            applyStimulus(op, f, 2, abortAt);
        end

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            checks++;
            $display("[TB] FAIL drain: got %0d pending required 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 Parameters: none; the block SHALL be fully fixed-function.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 Op  input  6  instruction opcode, Instr[31:26], from the instruction register.
REQ-005 Funct  input  6  R-type function field, Instr[5:0].
REQ-006 Zero  input  1  zero flag from the downstream ALU.
REQ-007 ALUControl  output  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-008 ALUSrcA  output  1  0 = PC, 1 = register A.
REQ-009 ALUSrcB  output  2  00 = register B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
REQ-010 PCSrc  output  2  00 = ALUResult, 01 = ALUOut, 10 = jump target.
REQ-011 IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, PCEn  output  1 each  standard multicycle datapath strobes.
REQ-012 State  output  4  current state encoding, for debug and verification.

Function
REQ-013 The block SHALL be a Moore FSM with these encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11.
REQ-014 Transitions SHALL be:
- FETCH->DECODE.
- DECODE on Op: lw 100011 or sw 101011 -> MEMADR; R-type 000000 -> EXECUTE; beq 000100 -> BRANCH; addi 001000 -> ADDIEXEC; j 000010 -> JUMP; any other Op -> FETCH.
- MEMADR->MEMRD if lw, MEMWR if sw.
- MEMRD->MEMWB.
- EXECUTE->ALUWB.
- ADDIEXEC->ADDIWB.
- MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP -> FETCH.
REQ-015 State encodings 12-15 SHALL transition to FETCH on the next edge and assert no write strobe.
REQ-016 Each state SHALL assert only the following; every unlisted output SHALL be 0:
- FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALU add, PCSrc=00, PCWrite.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALU add.
- MEMADR and ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALU add.
- MEMRD: IorD=1.
- MEMWR: IorD=1, MemWrite=1.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALU from Funct.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALU sub, PCSrc=01, Branch.
- JUMP: PCSrc=10, PCWrite.
REQ-017 The Funct decode in EXECUTE SHALL map 100000->010, 100010->110, 100100->000, 100101->001, 101010->111; any other Funct SHALL give 010.
REQ-018 In every state other than EXECUTE and BRANCH, ALUControl SHALL be 010.
REQ-019 PCEn SHALL equal PCWrite | (Branch & Zero), combinationally, within the same cycle as Zero.
REQ-020 Zero SHALL be ignored in every state except BRANCH.
REQ-021 Per-instruction latency in cycles SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal Op 2.

Reset
REQ-022 Asserting reset SHALL force State to FETCH immediately, without waiting for a clock edge.
REQ-023 While reset is high, MemWrite, IRWrite, RegWrite and PCEn SHALL be 0; all other outputs SHALL take their FETCH values.
REQ-024 On the first rising edge after reset deasserts, the FSM SHALL execute FETCH, with IRWrite=1 and PCEn=1.
REQ-025 Reset asserted in any state, including mid-instruction, SHALL abort that instruction with no further write strobe issued.

Verification
REQ-026 Reset then release, Op=100011 -> State sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-027 Op=000000, Funct=101010 -> states 0,1,6,7,0; ALUControl=111 in state 6; RegDst=1 and RegWrite=1 in state 7.
REQ-028 Op=000100, Zero=1 in BRANCH -> PCEn=1, PCSrc=01, ALUControl=110; repeated with Zero=0 -> PCEn=0.
REQ-029 Op=111111 -> states 0,1,0; MemWrite, RegWrite and PCEn stay 0 in state 1.
REQ-030 Op=101011, reset pulsed asynchronously mid-cycle while in MEMADR -> State=0 immediately; MemWrite never asserts.
REQ-031 Op=000010 -> states 0,1,11,0; PCSrc=10 and PCEn=1 in state 11.
